// File: rtl/soc_pkg.sv
// Shared constants for the SoC data-port responder: config window, register offsets, default RAM size.
package soc_pkg;

  localparam int          DEF_ADDR_W = 10;
  localparam logic [15:0] CONF_HI    = 16'hBFAF;

  localparam logic [15:0] LED_OFF    = 16'hF000;
  localparam logic [15:0] SWITCH_OFF = 16'hF004;
  localparam logic [15:0] NUM_OFF    = 16'hF008;
  localparam logic [15:0] TIMER_OFF  = 16'hF00C;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  wen);
    byte_merge = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) byte_merge[8*i +: 8] = new_val[8*i +: 8];
    end
  endfunction

endpackage

// File: rtl/bytewen_ram.sv
// Byte-writable single-port RAM, synchronous read-first: rdata is the pre-write word, one cycle later.
// Accepts an access every cycle; rdata holds while en is low.
module bytewen_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM port responder: decodes RAM vs config registers, fixed 1-cycle read-first latency.
// No backpressure; a request is accepted every cycle and rdata holds between requests.
module data_sram_responder
  import soc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  logic        is_conf;
  logic [15:0] conf_off;
  logic        conf_wr;
  logic        ram_en;
  logic [31:0] ram_rdata;
  logic [31:0] conf_rd;
  logic [31:0] conf_merged;
  logic [31:0] conf_q;
  logic        tgt_conf_q;
  logic [31:0] timer;
  logic        unused_bits;

  assign is_conf  = (data_sram_addr[31:16] == CONF_HI);
  assign conf_off = {data_sram_addr[15:2], 2'b00};
  assign conf_wr  = data_sram_en && is_conf && (data_sram_wen != 4'd0);
  assign ram_en   = data_sram_en && !is_conf;

  bytewen_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .wen   (data_sram_wen),
    .addr  (data_sram_addr[ADDR_W+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_rdata)
  );

  // Current register value doubles as the read-first response and the byte-merge base.
  always_comb begin
    conf_rd = 32'd0;
    case (conf_off)
      LED_OFF:    conf_rd = {16'd0, led};
      SWITCH_OFF: conf_rd = {24'd0, switch};
      NUM_OFF:    conf_rd = num_data;
      TIMER_OFF:  conf_rd = timer;
      default:    conf_rd = 32'd0;
    endcase
  end

  assign conf_merged = byte_merge(conf_rd, data_sram_wdata, data_sram_wen);
  assign unused_bits = ^{data_sram_addr[1:0], conf_merged[31:16]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led        <= 16'd0;
      num_data   <= 32'd0;
      timer      <= 32'd0;
      conf_q     <= 32'd0;
      tgt_conf_q <= 1'b1;
    end else begin
      if (data_sram_en) begin
        tgt_conf_q <= is_conf;
        if (is_conf) conf_q <= conf_rd;
      end

      if (conf_wr && conf_off == TIMER_OFF) timer <= conf_merged;
      else                                  timer <= timer + 32'd1;

      if (conf_wr && conf_off == LED_OFF) led      <= conf_merged[15:0];
      if (conf_wr && conf_off == NUM_OFF) num_data <= conf_merged;
    end
  end

  // Reset leaves the flag on the config side so rdata reads 0 regardless of RAM output.
  assign data_sram_rdata = tgt_conf_q ? conf_q : ram_rdata;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: vector table plus timer-wrap and mid-stream reset sequences.
module tb_data_sram_responder;

  logic        clk;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch;
  logic [15:0] led;
  logic [31:0] num_data;

  int checks;
  int errors;

  data_sram_responder #(.ADDR_W(10)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch          (switch),
    .led             (led),
    .num_data        (num_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  sw;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
    logic [31:0] exp_num;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive one request, let the next rising edge take it, then settle just after that edge.
  task automatic step(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata);
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [7:0] sw, input logic chk,
                              input logic [31:0] exp_rdata, input logic [15:0] exp_led,
                              input logic [31:0] exp_num);
    mk = '{en, wen, addr, wdata, sw, chk, exp_rdata, exp_led, exp_num};
  endfunction

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = mk(1, 4'hF, 32'h0000_0010, 32'h1122_3344, 8'h5A, 0, 32'h0,         16'h0,    32'h0);
    vecs[1]  = mk(1, 4'h0, 32'h0000_0010, 32'h0,         8'h5A, 1, 32'h1122_3344, 16'h0,    32'h0);
    vecs[2]  = mk(1, 4'h5, 32'h0000_0010, 32'hAABB_CCDD, 8'h5A, 1, 32'h1122_3344, 16'h0,    32'h0);
    vecs[3]  = mk(1, 4'h0, 32'h0000_0010, 32'h0,         8'h5A, 1, 32'h11BB_33DD, 16'h0,    32'h0);
    vecs[4]  = mk(1, 4'hF, 32'h0000_0014, 32'hCAFE_F00D, 8'h5A, 0, 32'h0,         16'h0,    32'h0);
    vecs[5]  = mk(1, 4'h0, 32'h0000_0014, 32'h0,         8'h5A, 1, 32'hCAFE_F00D, 16'h0,    32'h0);
    vecs[6]  = mk(1, 4'hF, 32'h0000_0014, 32'h0102_0304, 8'h5A, 1, 32'hCAFE_F00D, 16'h0,    32'h0);
    vecs[7]  = mk(1, 4'h0, 32'h0000_0014, 32'h0,         8'h5A, 1, 32'h0102_0304, 16'h0,    32'h0);
    vecs[8]  = mk(1, 4'h0, 32'h8000_0010, 32'h0,         8'h5A, 1, 32'h11BB_33DD, 16'h0,    32'h0);
    vecs[9]  = mk(1, 4'h0, 32'hBFAE_0010, 32'h0,         8'h5A, 1, 32'h11BB_33DD, 16'h0,    32'h0);
    vecs[10] = mk(1, 4'hF, 32'hBFAF_F000, 32'hFFFF_1234, 8'h5A, 1, 32'h0,         16'h1234, 32'h0);
    vecs[11] = mk(1, 4'h0, 32'hBFAF_F000, 32'h0,         8'h5A, 1, 32'h0000_1234, 16'h1234, 32'h0);
    vecs[12] = mk(1, 4'h2, 32'hBFAF_F000, 32'h0000_AB00, 8'h5A, 1, 32'h0000_1234, 16'hAB34, 32'h0);
    vecs[13] = mk(1, 4'hC, 32'hBFAF_F000, 32'hFFFF_FFFF, 8'h5A, 1, 32'h0000_AB34, 16'hAB34, 32'h0);
    vecs[14] = mk(1, 4'h0, 32'hBFAF_F002, 32'h0,         8'h5A, 1, 32'h0000_AB34, 16'hAB34, 32'h0);
    vecs[15] = mk(1, 4'h0, 32'hBFAF_F004, 32'h0,         8'h5A, 1, 32'h0000_005A, 16'hAB34, 32'h0);
    vecs[16] = mk(1, 4'hF, 32'hBFAF_F004, 32'h0,         8'h5A, 1, 32'h0000_005A, 16'hAB34, 32'h0);
    vecs[17] = mk(1, 4'hF, 32'hBFAF_F008, 32'h1234_5678, 8'h5A, 1, 32'h0,         16'hAB34, 32'h1234_5678);
    vecs[18] = mk(1, 4'h8, 32'hBFAF_F008, 32'hFF00_0000, 8'h5A, 1, 32'h1234_5678, 16'hAB34, 32'hFF34_5678);
    vecs[19] = mk(1, 4'h0, 32'hBFAF_F008, 32'h0,         8'h5A, 1, 32'hFF34_5678, 16'hAB34, 32'hFF34_5678);
    vecs[20] = mk(1, 4'h0, 32'hBFAF_F100, 32'h0,         8'h5A, 1, 32'h0,         16'hAB34, 32'hFF34_5678);
    vecs[21] = mk(1, 4'hF, 32'hBFAF_F100, 32'hDEAD_BEEF, 8'h5A, 1, 32'h0,         16'hAB34, 32'hFF34_5678);
    vecs[22] = mk(1, 4'h0, 32'h0000_0010, 32'h0,         8'h5A, 1, 32'h11BB_33DD, 16'hAB34, 32'hFF34_5678);
    vecs[23] = mk(0, 4'hF, 32'hBFAF_F000, 32'h0,         8'h5A, 1, 32'h11BB_33DD, 16'hAB34, 32'hFF34_5678);
    vecs[24] = mk(0, 4'h0, 32'hBFAF_F004, 32'h0,         8'h5A, 1, 32'h11BB_33DD, 16'hAB34, 32'hFF34_5678);
    vecs[25] = mk(1, 4'h0, 32'hBFAF_F100, 32'h0,         8'h5A, 1, 32'h0,         16'hAB34, 32'hFF34_5678);
    vecs[26] = mk(1, 4'h0, 32'hBFAF_F004, 32'h0,         8'hA5, 1, 32'h0000_00A5, 16'hAB34, 32'hFF34_5678);

    reset           = 1'b1;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    switch          = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_led",   {16'h0, led},    32'h0);
    check("reset_num",   num_data,        32'h0);
    #4 reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      switch = vecs[i].sw;
      step(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk_rdata) check($sformatf("vec%0d_rdata", i), data_sram_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
      check($sformatf("vec%0d_num", i), num_data, vecs[i].exp_num);
    end

    // Timer: load near wrap, two idle cycles, then consecutive reads see the wrap.
    step(1, 4'hF, 32'hBFAF_F00C, 32'hFFFF_FFFE);
    step(0, 4'h0, 32'h0, 32'h0);
    step(0, 4'h0, 32'h0, 32'h0);
    step(1, 4'h0, 32'hBFAF_F00C, 32'h0);
    check("timer_wrap0", data_sram_rdata, 32'h0000_0000);
    step(1, 4'h0, 32'hBFAF_F00C, 32'h0);
    check("timer_wrap1", data_sram_rdata, 32'h0000_0001);
    step(1, 4'h1, 32'hBFAF_F00C, 32'h0000_0077);
    check("timer_wr_old", data_sram_rdata, 32'h0000_0002);
    step(1, 4'h0, 32'hBFAF_F00C, 32'h0);
    check("timer_merged", data_sram_rdata, 32'h0000_0077);

    // Reset in the middle of a read stream.
    step(1, 4'h0, 32'h0000_0010, 32'h0);
    step(1, 4'h0, 32'h0000_0014, 32'h0);
    check("pre_rst_rdata", data_sram_rdata, 32'h0102_0304);
    #2 reset = 1'b1;
    #1;
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_led",   {16'h0, led},    32'h0);
    check("rst_num",   num_data,        32'h0);
    @(posedge clk);
    #4 reset = 1'b0;
    #1;
    step(1, 4'h0, 32'hBFAF_F00C, 32'h0);
    check("post_rst_timer0", data_sram_rdata, 32'h0);
    step(1, 4'h0, 32'hBFAF_F00C, 32'h0);
    check("post_rst_timer1", data_sram_rdata, 32'h0000_0001);
    step(1, 4'h0, 32'h0000_0010, 32'h0);
    check("post_rst_ram", data_sram_rdata, 32'h11BB_33DD);
    step(1, 4'hF, 32'h0000_0018, 32'h5555_AAAA);
    step(1, 4'h0, 32'h0000_0018, 32'h0);
    check("post_rst_wr_rd", data_sram_rdata, 32'h5555_AAAA);
    step(1, 4'h0, 32'hBFAF_F000, 32'h0);
    check("post_rst_led_rd", data_sram_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
